// File: rtl/wide_result_serializer_pkg.sv
// Shared types, default widths and the signature update used by the wide result serializer.
package wide_result_serializer_pkg;

    localparam int unsigned DEF_W  = 512;
    localparam int unsigned DEF_NW = 32;
    localparam int unsigned SIG_W  = 32;

    typedef enum logic [2:0] {
        E_ADD  = 3'd0,
        E_SUB  = 3'd1,
        E_AND  = 3'd2,
        E_OR   = 3'd3,
        E_XOR  = 3'd4,
        E_SHL  = 3'd5,
        E_ONES = 3'd6,
        E_NONE = 3'd7
    } op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    // Rotate left by one, then fold in the emitted word.
    function automatic logic [SIG_W-1:0] sig_update(input logic [SIG_W-1:0] i_sig,
                                                    input logic [SIG_W-1:0] i_word);
        return {i_sig[SIG_W-2:0], i_sig[SIG_W-1]} ^ i_word;
    endfunction

endpackage

// File: rtl/wide_result_serializer_word_select.sv
// Holds the accepted wide result and presents the NW-bit word selected by the beat index.
module wide_word_select
    import wide_result_serializer_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned NW    = DEF_NW,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [W-1:0]     i_data,
    input  logic [IDX_W-1:0] i_idx,
    output logic [NW-1:0]    o_word
);

    localparam int unsigned BEATS = W / NW;

    logic [W-1:0]                r_hold;
    logic [BEATS-1:0][NW-1:0]    w_words;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (i_load) begin
            r_hold <= i_data;
        end
    end

    // Packed-array view: element 0 is the least-significant word.
    assign w_words = r_hold;
    assign o_word  = w_words[i_idx];

endmodule

// File: rtl/wide_result_serializer.sv
// Serializes one W-bit ALU result into W/NW narrow beats, LSW first, with a running signature.
module wide_result_serializer
    import wide_result_serializer_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned NW = DEF_NW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [2:0]    in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] out_data,
    output logic          out_first,
    output logic          out_last,
    output logic [2:0]    out_tag,
    output logic [31:0]   sig,
    output logic [31:0]   done_cnt
);

    localparam int unsigned BEATS = W / NW;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    ser_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_tag;
    logic [31:0]      r_sig;
    logic [31:0]      r_done;

    logic [NW-1:0]    w_word;
    logic             w_sending;
    logic             w_is_last;
    logic             w_accept;

    assign w_sending = (r_state == S_SEND);
    assign w_is_last = w_sending && (r_idx == LAST_IDX);

    // Ready looks only at state and out_ready so upstream can never form a loop through in_valid.
    assign in_ready  = (r_state == S_IDLE) || (w_is_last && out_ready);
    assign w_accept  = in_valid && in_ready;

    wide_word_select #(
        .W     (W),
        .NW    (NW),
        .IDX_W (IDX_W)
    ) u_word_select (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_data (in_data),
        .i_idx  (r_idx),
        .o_word (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_tag   <= '0;
            r_sig   <= '0;
            r_done  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_tag   <= in_tag;
                        r_idx   <= '0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        r_sig <= sig_update(r_sig, w_word);
                        if (r_idx == LAST_IDX) begin
                            r_done <= r_done + 32'd1;
                            r_idx  <= '0;
                            // A waiting result is chained in with no idle bubble.
                            if (in_valid) begin
                                r_tag <= in_tag;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = w_sending;
        out_data  = w_sending ? w_word : '0;
        out_first = w_sending && (r_idx == '0);
        out_last  = w_is_last;
        out_tag   = r_tag;
        sig       = r_sig;
        done_cnt  = r_done;
    end

endmodule

// File: tb/tb_wide_result_serializer.sv
// Randomized and directed bench for wide_result_serializer against a beat-queue reference model.
module tb_wide_result_serializer;
    import wide_result_serializer_pkg::*;

    localparam int W     = 512;
    localparam int NW    = 32;
    localparam int BEATS = W / NW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [2:0]    in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] out_data;
    logic          out_first;
    logic          out_last;
    logic [2:0]    out_tag;
    logic [31:0]   sig;
    logic [31:0]   done_cnt;

    always #5 clk = ~clk;

    wide_result_serializer #(
        .W  (W),
        .NW (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .out_tag   (out_tag),
        .sig       (sig),
        .done_cnt  (done_cnt)
    );

    typedef struct {
        logic [31:0] d;
        logic        first;
        logic        last;
        logic [2:0]  tag;
    } beat_t;

    beat_t       m_q[$];
    logic [31:0] m_sig;
    logic [31:0] m_cnt;
    int          n_checks;
    int          n_errors;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        for (int i = 0; i < BEATS; i++) r[i*NW +: NW] = $urandom();
        return r;
    endfunction

    // One cycle: drive at negedge, check outputs against the model, then advance the model.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                        input logic [2:0] t, input logic rdy);
        logic  exp_rdy;
        beat_t b;
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; in_tag = t; out_ready = rdy;
        #1;
        exp_rdy = (m_q.size() == 0) || (m_q.size() == 1 && rdy);
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check_eq("out_data", out_data, m_q[0].d);
            check_eq("out_first", out_first, m_q[0].first);
            check_eq("out_last", out_last, m_q[0].last);
            check_eq("out_tag", out_tag, m_q[0].tag);
        end else begin
            check_eq("idle_first", out_first, 1'b0);
            check_eq("idle_last", out_last, 1'b0);
        end
        check_eq("sig", sig, m_sig);
        check_eq("done_cnt", done_cnt, m_cnt);
        if (r) begin
            m_q.delete();
            m_sig = '0;
            m_cnt = '0;
        end else begin
            if (m_q.size() != 0 && rdy) begin
                b = m_q.pop_front();
                m_sig = {m_sig[30:0], m_sig[31]} ^ b.d;
                if (b.last) m_cnt++;
            end
            if (v && exp_rdy) begin
                for (int i = 0; i < BEATS; i++) begin
                    b.d     = 32'(d >> (i * NW));
                    b.first = (i == 0);
                    b.last  = (i == BEATS - 1);
                    b.tag   = t;
                    m_q.push_back(b);
                end
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 3'd0, 1'b0);
        step(1'b1, 1'b0, '0, 3'd0, 1'b0);
    endtask

    logic [W-1:0]  w_rand;
    logic [NW-1:0] stall_data;
    logic [2:0]    stall_tag;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
        m_sig = '0; m_cnt = '0; n_checks = 0; n_errors = 0;

        // Reset values.
        do_reset();
        step(1'b0, 1'b0, '0, 3'd0, 1'b0);
        check_eq("rst_data", out_data, 32'h0);
        check_eq("rst_tag", out_tag, 3'd0);
        check_eq("rst_in_ready", in_ready, 1'b1);

        // Single small value: 0x171 then fifteen zero words.
        step(1'b0, 1'b1, 512'h171, E_ONES, 1'b1);
        for (int i = 0; i < BEATS; i++) step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        check_eq("t1_sig", sig, 32'h00B88000);
        check_eq("t1_cnt", done_cnt, 32'd1);
        check_eq("t1_in_ready", in_ready, 1'b1);

        // All-ones result: signature alternates between all-ones and zero.
        do_reset();
        step(1'b0, 1'b1, {W{1'b1}}, E_AND, 1'b1);
        for (int i = 0; i < BEATS; i++) begin
            step(1'b0, 1'b0, '0, 3'd0, 1'b1);
            check_eq("t2_alt_sig", sig, (i % 2 == 1) ? 32'hFFFFFFFF : 32'h0);
        end
        step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        check_eq("t2_sig", sig, 32'h0);

        // Three-cycle stall at beat 5 must not change data, tag or signature.
        do_reset();
        step(1'b0, 1'b1, 512'h171, E_XOR, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 3'd0, 1'b0);
            if (i == 0) begin
                stall_data = out_data;
                stall_tag  = out_tag;
            end else begin
                check_eq("t3_stall_data", out_data, stall_data);
                check_eq("t3_stall_tag", out_tag, stall_tag);
                check_eq("t3_stall_valid", out_valid, 1'b1);
            end
        end
        for (int i = 5; i < BEATS; i++) step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        check_eq("t3_sig", sig, 32'h00B88000);
        check_eq("t3_cnt", done_cnt, 32'd1);

        // Back-to-back results chained on the last-beat handshake.
        do_reset();
        step(1'b0, 1'b1, rand_wide(), E_ADD, 1'b1);
        for (int i = 0; i < BEATS - 1; i++) step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        step(1'b0, 1'b1, rand_wide(), E_SUB, 1'b1);
        check_eq("t4_in_ready_last", in_ready, 1'b1);
        step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        check_eq("t4_no_bubble", out_valid, 1'b1);
        check_eq("t4_first", out_first, 1'b1);
        for (int i = 1; i < BEATS; i++) step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        check_eq("t4_cnt", done_cnt, 32'd2);

        // Reset during beat 7 drops the result.
        step(1'b0, 1'b1, rand_wide(), E_OR, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        step(1'b1, 1'b0, '0, 3'd0, 1'b1);
        step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        check_eq("t5_valid", out_valid, 1'b0);
        check_eq("t5_in_ready", in_ready, 1'b1);
        check_eq("t5_sig", sig, 32'h0);
        check_eq("t5_cnt", done_cnt, 32'h0);
        step(1'b0, 1'b1, rand_wide(), E_SHL, 1'b1);
        for (int i = 0; i < BEATS; i++) step(1'b0, 1'b0, '0, 3'd0, 1'b1);

        // in_valid together with reset is ignored.
        step(1'b1, 1'b1, rand_wide(), E_NONE, 1'b1);
        step(1'b0, 1'b0, '0, 3'd0, 1'b1);
        check_eq("t6_valid", out_valid, 1'b0);
        check_eq("t6_in_ready", in_ready, 1'b1);

        // Random traffic with backpressure and occasional reset.
        for (int n = 0; n < 1500; n++) begin
            w_rand = rand_wide();
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), w_rand,
                 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7));
        end
        for (int n = 0; n < 3 * BEATS; n++) step(1'b0, 1'b0, '0, 3'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wide_result_serializer.md
# wide_result_serializer

Downstream stage of the wide ALU: accepts one registered W-bit ALU result plus its op tag over a valid/ready handshake, and emits it as W/NW narrow words, least-significant word first, over a second valid/ready handshake. Maintains a running 32-bit rotate-XOR signature of every emitted word and a count of completed results, so benches and the host check a 512-bit datapath through a narrow port. Sits between the ALU result register and the narrow host/exchange channel.

## Interface
- W, 512, input result width; must be a multiple of NW
- NW, 32, output word width; fixed at 32 in this revision
- BEATS, W/NW (derived, localparam), words per result
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset; sampled on posedge clk
- in_valid  input  1  upstream result valid
- in_ready  output  1  serializer can take a result this cycle
- in_data  input  W  ALU result
- in_tag  input  3  op_t encoding of the producing op
- out_valid  output  1  out_data holds a valid beat
- out_ready  input  1  downstream accepts the beat
- out_data  output  NW  current word
- out_first  output  1  current beat is word 0
- out_last  output  1  current beat is word BEATS-1
- out_tag  output  3  tag of the result being sent
- sig  output  32  running signature
- done_cnt  output  32  results fully emitted since reset

## Operation
- FSM states: IDLE, SEND.
- IDLE: in_ready=1, out_valid=0. On in_valid: latch in_data/in_tag into hold register, beat index=0, go SEND.
- SEND: out_valid=1, out_data=hold[idx*NW +: NW], out_first=(idx==0), out_last=(idx==BEATS-1), out_tag=latched tag.
- Beat handshake = out_valid & out_ready: idx increments; sig <= {sig[30:0],sig[31]} ^ out_data.
- Last-beat handshake: done_cnt increments (wraps at 2^32). If in_valid same cycle, new result latched, idx=0, stay SEND (no bubble); else go IDLE.
- in_ready = IDLE, or (SEND & out_last & out_ready). Combinational from state and out_ready only; never depends on in_valid.
- out_valid must not drop and out_data/out_tag must not change while out_valid & !out_ready.
- rst: state=IDLE, idx=0, hold=0, tag=0, sig=0, done_cnt=0. Outputs after reset: in_ready=1, out_valid=0, out_data=0, out_first=0, out_last=0, out_tag=0. rst wins over any simultaneous handshake; an in-flight result is dropped, not counted.
- out_first/out_last forced 0 when out_valid=0.

## Timing
- Input accepted at edge t -> beat 0 presented in cycle t+1 (latency 1).
- With out_ready held high: BEATS consecutive beats, one per cycle; sustained throughput one result per BEATS cycles.
- sig and done_cnt updated on the edge that completes the handshake, visible next cycle.
- Backpressure stall of k cycles extends the result by exactly k cycles.

## Structure
- Shared package: op_t enum (E_ADD..E_NONE, 3-bit), W and NW defaults, sig update function (rotate-left-1 then XOR).
- One sub-module natural: wide_word_select (hold register + beat index → NW-bit word mux); FSM, handshakes and counters in the top.

## Test plan
- Reset then in_data=512'h171, tag=E_ONES, out_ready=1 -> beats 0x00000171 then 15×0x0; out_first on beat 0, out_last on beat 15; final sig=0x00B88000, done_cnt=1, in_ready=1 after.
- in_data all-ones, out_ready=1 -> 16 beats of 0xFFFFFFFF; sig alternates 0xFFFFFFFF/0x0 and ends 0x00000000.
- Drop out_ready for 3 cycles at beat 5 -> out_data, out_tag, out_valid stable those 3 cycles; result completes 3 cycles later; sig identical to unstalled run.
- Two results back-to-back with in_valid high on the last-beat handshake -> in_ready=1 that cycle, beat 0 of result 2 next cycle, no idle cycle, done_cnt=2.
- rst asserted during beat 7 -> next cycle out_valid=0, in_ready=1, sig=0, done_cnt=0; next input serializes cleanly from beat 0.
- in_valid with rst in the same cycle -> input not accepted; state IDLE, out_valid=0 next cycle.
